// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory handshake,
// retire counter and illegal-op trap. Optional jump support is enabled by defining MCU_JUMP_EN.
module multicycle_control_unit #(
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opCode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemReadEn,
  output logic               MemWriteEn,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWriteEn,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state_o,
  output logic [CNT_W-1:0]   instr_count,
  output logic               illegal
);

  localparam int unsigned OP_W   = 6;
  localparam int unsigned CODE_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
`ifdef MCU_JUMP_EN
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
`endif

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [CODE_W-1:0] ALU_ADD = 3'd0;
  localparam logic [CODE_W-1:0] ALU_SUB = 3'd1;
  localparam logic [CODE_W-1:0] ALU_AND = 3'd2;
  localparam logic [CODE_W-1:0] ALU_OR  = 3'd3;
  localparam logic [CODE_W-1:0] ALU_SLT = 3'd4;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
`ifdef MCU_JUMP_EN
    S_JUMP   = 4'd12,
`endif
    S_TRAP   = 4'd13
  } state_t;

  typedef struct packed {
    logic              pcwrite;
    logic              pcwritecond;
    logic              iord;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              regdst;
    logic              regwrite;
    logic              alusrca;
    logic [1:0]        alusrcb;
    logic [1:0]        pcsource;
    logic [CODE_W-1:0] aluop;
  } ctrl_t;

  state_t            state;
  state_t            state_n;
  logic              retire;
  logic [OP_W-1:0]   op_q;
  logic [OP_W-1:0]   fn_q;
  logic [OP_W-1:0]   fn_eff;
  ctrl_t             ctrl_q;
  logic              fetch_grant;
  logic [CNT_W-1:0]  count_q;
  logic              illegal_q;

  function automatic logic is_rfunct(input logic [OP_W-1:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic logic [CODE_W-1:0] funct_aluop(input logic [OP_W-1:0] fn);
    logic [CODE_W-1:0] code;
    case (fn)
      FN_SUB:  code = ALU_SUB;
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_SLT:  code = ALU_SLT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Moore decode of a state into its control word; used on the next state so outputs are registered.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [OP_W-1:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.iord    = 1'b1;
        c.memread = 1'b1;
      end
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = funct_aluop(fn);
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = ALU_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = ALU_ADD;
      end
      S_ADDIWB: c.regwrite = 1'b1;
`ifdef MCU_JUMP_EN
      S_JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  // funct is only valid in DECODE; later states use the latched copy.
  assign fn_eff = (state == S_DECODE) ? funct : fn_q;

  // Next-state and retire decode.
  always_comb begin
    state_n = state;
    retire  = 1'b0;
    case (state)
      S_RST:   state_n = S_FETCH;
      S_FETCH: if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (opCode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = is_rfunct(funct) ? S_EXEC : S_TRAP;
          OP_BEQ:       state_n = S_BRANCH;
          OP_ADDI:      state_n = S_ADDIEX;
`ifdef MCU_JUMP_EN
          OP_J:         state_n = S_JUMP;
`endif
          default:      state_n = S_TRAP;
        endcase
      end
      S_MEMADR: state_n = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWB: begin
        state_n = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_n = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_n = S_ALUWB;
      S_ALUWB, S_BRANCH, S_ADDIWB: begin
        state_n = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDIEX: state_n = S_ADDIWB;
`ifdef MCU_JUMP_EN
      S_JUMP: begin
        state_n = S_FETCH;
        retire  = 1'b1;
      end
`endif
      S_TRAP:   state_n = S_TRAP;
      default:  state_n = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RST;
      op_q      <= '0;
      fn_q      <= '0;
      ctrl_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state  <= state_n;
      ctrl_q <= decode_ctrl(state_n, fn_eff);
      if (state == S_DECODE) begin
        op_q <= opCode;
        fn_q <= funct;
      end
      if (retire) count_q <= count_q + CNT_W'(1);
      if (state_n == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // IR/PC load in FETCH follows the memory handshake of the current cycle.
  assign fetch_grant = (state == S_FETCH) && mem_ready && !rst;

  assign PCWrite     = ctrl_q.pcwrite | fetch_grant;
  assign IRWrite     = fetch_grant;
  assign PCWriteCond = ctrl_q.pcwritecond;
  assign IorD        = ctrl_q.iord;
  assign MemReadEn   = ctrl_q.memread;
  assign MemWriteEn  = ctrl_q.memwrite;
  assign MemtoReg    = ctrl_q.memtoreg;
  assign RegDst      = ctrl_q.regdst;
  assign RegWriteEn  = ctrl_q.regwrite;
  assign ALUSrcA     = ctrl_q.alusrca;
  assign ALUSrcB     = ctrl_q.alusrcb;
  assign PCSource    = ctrl_q.pcsource;
  assign ALUOp       = ALUOP_W'(ctrl_q.aluop);
  assign state_o     = state;
  assign instr_count = count_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (CNT_W=4 so counter wrap is reachable quickly).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opCode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemReadEn, MemWriteEn, IRWrite;
  logic       MemtoReg, RegDst, RegWriteEn, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state_o;
  logic [3:0] instr_count;
  logic       illegal;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt;
  logic [16:0] ctl;
  logic [16:0] e_fetch_rdy, e_fetch_wait, e_dec;

  multicycle_control_unit #(.ALUOP_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemReadEn(MemReadEn),
    .MemWriteEn(MemWriteEn), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWriteEn(RegWriteEn), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .state_o(state_o), .instr_count(instr_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign ctl = {PCWrite, PCWriteCond, IorD, MemReadEn, MemWriteEn, IRWrite, MemtoReg,
                RegDst, RegWriteEn, ALUSrcA, ALUSrcB, PCSource, ALUOp};

  function automatic logic [16:0] mk(input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa,
                                     input logic [1:0] sb, ps, input logic [2:0] op);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_cnt = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opCode = 6'h00; funct = 6'h00;
    tick(); tick();
    checks++;
    if ({state_o, ctl, illegal, instr_count} !== 26'd0) begin
      errors++; $display("FAIL reset_hold got %h want 0", {state_o, ctl, illegal, instr_count});
    end
    rst = 1'b0;
    tick();
    exp_cnt = 4'd0;
    checks++;
    if ({state_o, ctl} !== {4'd1, e_fetch_rdy}) begin
      errors++; $display("FAIL reset_release got %h want %h", {state_o, ctl}, {4'd1, e_fetch_rdy});
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({state_o, ctl} !== {4'd1, e_fetch_wait}) begin
      errors++; $display("FAIL fetch_wait got %h want %h", {state_o, ctl}, {4'd1, e_fetch_wait});
    end
  endtask

  task automatic test_add();
    opCode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    tick();
    checks++;
    if ({state_o, ctl} !== {4'd2, e_dec}) begin
      errors++; $display("FAIL add_decode got %h want %h", {state_o, ctl}, {4'd2, e_dec});
    end
    tick();
    checks++;
    if ({state_o, ctl} !== {4'd7, mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'd0)}) begin
      errors++; $display("FAIL add_exec got %h", {state_o, ctl});
    end
    tick();
    checks++;
    if ({state_o, ctl, instr_count} !== {4'd8, mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'd0), exp_cnt}) begin
      errors++; $display("FAIL add_aluwb got %h cnt %0d want cnt %0d", {state_o, ctl}, instr_count, exp_cnt);
    end
    tick();
    exp_cnt++;
    checks++;
    if ({state_o, instr_count} !== {4'd1, exp_cnt}) begin
      errors++; $display("FAIL add_retire state %0d cnt %0d want 1/%0d", state_o, instr_count, exp_cnt);
    end
  endtask

  task automatic test_rtypes();
    logic [5:0] fns [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] ops [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 4; i++) begin
      opCode = 6'h00; funct = fns[i]; mem_ready = 1'b1;
      tick(); tick();
      checks++;
      if ({state_o, ctl} !== {4'd7, mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,ops[i])}) begin
        errors++; $display("FAIL rtype_exec funct %h got ALUOp %0d want %0d", fns[i], ALUOp, ops[i]);
      end
      tick(); tick();
      exp_cnt++;
      checks++;
      if ({state_o, instr_count} !== {4'd1, exp_cnt}) begin
        errors++; $display("FAIL rtype_retire state %0d cnt %0d want 1/%0d", state_o, instr_count, exp_cnt);
      end
    end
  endtask

  task automatic test_lw();
    opCode = 6'h23; funct = 6'h00; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if ({state_o, ctl} !== {4'd3, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'd0)}) begin
      errors++; $display("FAIL lw_memadr got %h", {state_o, ctl});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({state_o, ctl} !== {4'd4, mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'd0)}) begin
        errors++; $display("FAIL lw_memrd cycle %0d got %h", i, {state_o, ctl});
      end
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    checks++;
    if ({state_o, ctl, instr_count} !== {4'd5, mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'd0), exp_cnt}) begin
      errors++; $display("FAIL lw_memwb got %h cnt %0d", {state_o, ctl}, instr_count);
    end
    tick();
    exp_cnt++;
    checks++;
    if ({state_o, instr_count} !== {4'd1, exp_cnt}) begin
      errors++; $display("FAIL lw_retire state %0d cnt %0d want 1/%0d", state_o, instr_count, exp_cnt);
    end
  endtask

  task automatic test_sw();
    opCode = 6'h2B; mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({state_o, ctl, instr_count} !== {4'd6, mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'd0), exp_cnt}) begin
      errors++; $display("FAIL sw_memwr got %h cnt %0d", {state_o, ctl}, instr_count);
    end
    tick();
    exp_cnt++;
    checks++;
    if ({state_o, instr_count} !== {4'd1, exp_cnt}) begin
      errors++; $display("FAIL sw_retire state %0d cnt %0d want 1/%0d", state_o, instr_count, exp_cnt);
    end
  endtask

  task automatic test_beq();
    opCode = 6'h04; mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({state_o, ctl} !== {4'd9, mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'd1)}) begin
      errors++; $display("FAIL beq_branch got %h", {state_o, ctl});
    end
    tick();
    exp_cnt++;
    checks++;
    if ({state_o, instr_count} !== {4'd1, exp_cnt}) begin
      errors++; $display("FAIL beq_retire state %0d cnt %0d want 1/%0d", state_o, instr_count, exp_cnt);
    end
  endtask

  task automatic test_addi();
    opCode = 6'h08; mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({state_o, ctl} !== {4'd10, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'd0)}) begin
      errors++; $display("FAIL addi_ex got %h", {state_o, ctl});
    end
    tick();
    checks++;
    if ({state_o, ctl} !== {4'd11, mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'd0)}) begin
      errors++; $display("FAIL addi_wb got %h", {state_o, ctl});
    end
    tick();
    exp_cnt++;
    checks++;
    if ({state_o, instr_count} !== {4'd1, exp_cnt}) begin
      errors++; $display("FAIL addi_retire state %0d cnt %0d want 1/%0d", state_o, instr_count, exp_cnt);
    end
  endtask

  task automatic test_rst_mid();
    opCode = 6'h2B; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({state_o, MemWriteEn} !== {4'd6, 1'b1}) begin
      errors++; $display("FAIL mid_hold state %0d MemWriteEn %b want 6/1", state_o, MemWriteEn);
    end
    rst = 1'b1; mem_ready = 1'b1;
    tick();
    checks++;
    if ({state_o, ctl, instr_count} !== 25'd0) begin
      errors++; $display("FAIL mid_rst got %h want 0", {state_o, ctl, instr_count});
    end
    rst = 1'b0;
    tick();
    exp_cnt = 4'd0;
  endtask

  task automatic test_wrap();
    do_reset();
    opCode = 6'h00; funct = 6'h25; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat (4) tick();
      if (i == 14) begin
        checks++;
        if (instr_count !== 4'd15) begin
          errors++; $display("FAIL wrap_max got %0d want 15", instr_count);
        end
      end
    end
    checks++;
    if ({state_o, instr_count} !== {4'd1, 4'd0}) begin
      errors++; $display("FAIL wrap_zero state %0d cnt %0d want 1/0", state_o, instr_count);
    end
    exp_cnt = 4'd0;
  endtask

  task automatic test_jump();
    opCode = 6'h02; mem_ready = 1'b1;
    tick(); tick();
`ifdef MCU_JUMP_EN
    checks++;
    if ({state_o, ctl} !== {4'd12, mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'd0)}) begin
      errors++; $display("FAIL jump_state got %h", {state_o, ctl});
    end
    tick();
    exp_cnt++;
    checks++;
    if ({state_o, instr_count} !== {4'd1, exp_cnt}) begin
      errors++; $display("FAIL jump_retire state %0d cnt %0d want 1/%0d", state_o, instr_count, exp_cnt);
    end
`else
    checks++;
    if ({state_o, ctl, illegal} !== {4'd13, 17'd0, 1'b1}) begin
      errors++; $display("FAIL jump_trap got %h illegal %b", {state_o, ctl}, illegal);
    end
`endif
  endtask

  task automatic test_trap();
    do_reset();
    opCode = 6'h3F; funct = 6'h20; mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({state_o, ctl, illegal} !== {4'd13, 17'd0, 1'b1}) begin
      errors++; $display("FAIL trap_enter got %h illegal %b", {state_o, ctl}, illegal);
    end
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      opCode = 6'h00;
      tick();
      checks++;
      if ({state_o, ctl, illegal, instr_count} !== {4'd13, 17'd0, 1'b1, 4'd0}) begin
        errors++; $display("FAIL trap_hold cycle %0d got %h illegal %b cnt %0d", i, {state_o, ctl}, illegal, instr_count);
      end
    end
    do_reset();
    checks++;
    if ({state_o, illegal} !== {4'd1, 1'b0}) begin
      errors++; $display("FAIL trap_clear state %0d illegal %b want 1/0", state_o, illegal);
    end
    opCode = 6'h00; funct = 6'h00; mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({state_o, ctl, illegal} !== {4'd13, 17'd0, 1'b1}) begin
      errors++; $display("FAIL trap_funct got %h illegal %b", {state_o, ctl}, illegal);
    end
  endtask

  initial begin
    e_fetch_rdy  = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,3'd0);
    e_fetch_wait = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'd0);
    e_dec        = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'd0);
    rst = 1'b1; opCode = '0; funct = '0; mem_ready = 1'b0; exp_cnt = '0;
    test_reset();
    test_add();
    test_rtypes();
    test_lw();
    test_sw();
    test_beq();
    test_addi();
    test_rst_mid();
    test_wrap();
    test_jump();
    test_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
